packet_sum_pipeline: RTL

Parametrised successor to the fixed-latency packet adder. Adds in_a+in_b on every accepted beat, as before. Also keeps a running per-packet total, beat count and overflow flag, all reset at packet boundaries (in_last). Data moves through an LAT-stage valid/ready pipeline with per-stage stall and bubble collapsing, so input acceptance no longer simply mirrors out_ready. Sits between the packet source and the downstream consumer on the streaming datapath.

---
 rtl/packet_sum_pipeline_if.sv | 28 ++
 rtl/packet_sum_pipeline.sv | 101 ++++++++++
 2 files changed

// File: rtl/packet_sum_pipeline_if.sv
// rtl/packet_sum_pipeline_if.sv - input/output beat stream bundle for packet_sum_pipeline
interface packet_sum_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH:0]           out_sum;
  logic                     out_last;
  logic [WIDTH+CNT_W-1:0]   out_total;
  logic [CNT_W-1:0]         out_beats;
  logic                     out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_total, out_beats, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_total, out_beats, out_ovf
  );
endinterface

// File: rtl/packet_sum_pipeline.sv
// rtl/packet_sum_pipeline.sv - per-beat adder with running packet total in an LAT-stage elastic pipeline
module packet_sum_pipeline #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int CNT_W = 8,
  parameter int SAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packet_sum_pipeline_if.slave bus
);
  localparam int TW = WIDTH + CNT_W;
  localparam int PW = (WIDTH + 1) + 1 + TW + CNT_W + 1;

  logic [LAT-1:0] v;
  logic [LAT-1:0] adv;
  logic [PW-1:0]  pay [LAT];
  logic           src_v [LAT];
  logic [PW-1:0]  src_pay [LAT];
  logic           chain_full;

  logic [TW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;
  logic             first;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [TW-1:0]    base;
  logic [TW:0]      t;
  logic             wrap;
  logic [TW-1:0]    total_n;
  logic             ovf_n;
  logic [CNT_W-1:0] beats_n;
  logic [PW-1:0]    pay_in;

  // A stage may advance when the output drains or any stage at/downstream of it is empty.
  always_comb begin
    chain_full = 1'b1;
    adv        = '0;
    for (int k = LAT - 1; k >= 0; k--) begin
      chain_full = chain_full & v[k];
      adv[k]     = bus.out_ready | ~chain_full;
    end
  end

  assign accept = bus.in_valid & adv[0];

  always_comb begin
    sum     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    base    = first ? '0 : acc;
    t       = {1'b0, base} + {{(TW - WIDTH){1'b0}}, sum};
    wrap    = t[TW];
    total_n = (wrap && SAT != 0) ? '1 : t[TW-1:0];
    ovf_n   = (~first & ovf_r) | wrap;
    beats_n = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
    pay_in  = {sum, bus.in_last, total_n, beats_n, ovf_n};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      first <= 1'b1;
    end else if (accept) begin
      acc   <= total_n;
      cnt   <= beats_n;
      ovf_r <= ovf_n;
      first <= bus.in_last;
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_v[k]   = bus.in_valid;
      assign src_pay[k] = pay_in;
    end else begin : g_tail
      assign src_v[k]   = v[k-1];
      assign src_pay[k] = pay[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) pay[k] <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (adv[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) pay[k] <= src_pay[k];
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[LAT-1];
  assign {bus.out_sum, bus.out_last, bus.out_total, bus.out_beats, bus.out_ovf} = pay[LAT-1];
endmodule
